// File: rtl/pointer_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pointer_unit                                                  |
// | Purpose  : Holds the two memory pointers P0/P1 and maps them onto the    |
// |            IP (fetch) and DP (data) roles via p_selector. IP increments  |
// |            on request, DP bytes load from the DI bus, the address bus is |
// |            driven from IP or DP, and DP bytes are sourced onto ALU B.    |
// | Ports    : clk, rst        - clock (CPU n_clk), sync active-high reset   |
// |            inc_ip          - IP <= IP+1                                  |
// |            p_selector      - 0: IP=P0/DP=P1, 1: IP=P1/DP=P0              |
// |            n_we_pl/n_we_ph - active-low DP low/high byte load from di    |
// |            di              - internal DI bus                             |
// |            addr_dp         - address source select (0: IP, 1: DP)        |
// |            n_oe_pl_alu/ph  - active-low DP byte drive onto alu_b         |
// |            n_mem_rdy       - active-low ready; high freezes pointers     |
// |            address, alu_b, alu_b_en, ip, dp - outputs                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pointer_unit #(
  parameter int          AW       = 16,
  parameter logic [AW-1:0] RESET_P0 = '0,
  parameter logic [AW-1:0] RESET_P1 = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_ip,
  input  logic          p_selector,
  input  logic          n_we_pl,
  input  logic          n_we_ph,
  input  logic [7:0]    di,
  input  logic          addr_dp,
  input  logic          n_oe_pl_alu,
  input  logic          n_oe_ph_alu,
  input  logic          n_mem_rdy,
  output logic [AW-1:0] address,
  output logic [7:0]    alu_b,
  output logic          alu_b_en,
  output logic [AW-1:0] ip,
  output logic [AW-1:0] dp
);

  localparam logic [AW-1:0] C_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0]   r_p0;
  logic [AW-1:0]   r_p1;
  logic [AW-1:0]   w_ip_next;
  logic [AW-1:0]   w_dp_next;
  logic [AW-1:0]   w_p0_next;
  logic [AW-1:0]   w_p1_next;
  // Zero-extended copies so the high byte can be sliced for any AW >= 9.
  logic [AW+7:0]   w_di_ext;
  logic [AW+7:0]   w_dp_ext;

  assign w_di_ext = {{AW{1'b0}}, di};
  assign w_dp_ext = {8'h00, dp};

  // Role mapping follows the current selector.
  assign ip      = p_selector ? r_p1 : r_p0;
  assign dp      = p_selector ? r_p0 : r_p1;
  assign address = addr_dp ? dp : ip;

  // PL has priority over PH if both are asserted.
  always_comb begin
    alu_b    = 8'h00;
    alu_b_en = 1'b0;
    if (!n_oe_pl_alu) begin
      alu_b    = dp[7:0];
      alu_b_en = 1'b1;
    end else if (!n_oe_ph_alu) begin
      alu_b    = w_dp_ext[15:8];
      alu_b_en = 1'b1;
    end
  end

  // Next values are computed in role space and mapped back to P0/P1 with
  // the selector seen at this edge, so a swap on the same edge increments
  // the old IP register (return link).
  always_comb begin
    w_ip_next = inc_ip ? (ip + C_ONE) : ip;
    w_dp_next = dp;
    if (!n_we_pl) begin
      w_dp_next[7:0] = di;
    end
    if (!n_we_ph) begin
      w_dp_next[AW-1:8] = w_di_ext[AW-9:0];
    end
    if (p_selector) begin
      w_p0_next = w_dp_next;
      w_p1_next = w_ip_next;
    end else begin
      w_p0_next = w_ip_next;
      w_p1_next = w_dp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0 <= RESET_P0;
      r_p1 <= RESET_P1;
    end else if (!n_mem_rdy) begin
      r_p0 <= w_p0_next;
      r_p1 <= w_p1_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pointer_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pointer_unit                                               |
// | Purpose  : Self-checking bench for pointer_unit: directed scenarios with |
// |            literal expectations plus randomized stimulus compared every  |
// |            cycle against a role-level behavioural model.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pointer_unit;

  localparam int AW = 16;
  localparam logic [15:0] C_RP0 = 16'h0000;
  localparam logic [15:0] C_RP1 = 16'h0000;

  logic          clk = 1'b0;
  logic          rst, inc_ip, p_selector, n_we_pl, n_we_ph;
  logic [7:0]    di;
  logic          addr_dp, n_oe_pl_alu, n_oe_ph_alu, n_mem_rdy;
  logic [AW-1:0] address, ip, dp;
  logic [7:0]    alu_b;
  logic          alu_b_en;

  int tests = 0;
  int fails = 0;
  int protocol_events = 0;

  always #5 clk = ~clk;

  pointer_unit #(.AW(AW), .RESET_P0(C_RP0), .RESET_P1(C_RP1)) dut (
    .clk(clk), .rst(rst), .inc_ip(inc_ip), .p_selector(p_selector),
    .n_we_pl(n_we_pl), .n_we_ph(n_we_ph), .di(di), .addr_dp(addr_dp),
    .n_oe_pl_alu(n_oe_pl_alu), .n_oe_ph_alu(n_oe_ph_alu), .n_mem_rdy(n_mem_rdy),
    .address(address), .alu_b(alu_b), .alu_b_en(alu_b_en), .ip(ip), .dp(dp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ptr[k] is physical register Pk; the IP role is ptr[p_selector].
  logic [15:0] ptr [2];
  bit          model_valid = 0;

  always @(posedge clk) begin
    int          i;
    int          d;
    logic [15:0] nip;
    logic [15:0] ndp;
    if (rst) begin
      ptr[0]      <= C_RP0;
      ptr[1]      <= C_RP1;
      model_valid <= 1;
    end else if (model_valid && !n_mem_rdy) begin
      i   = p_selector ? 1 : 0;
      d   = 1 - i;
      nip = 16'((32'(ptr[i]) + (inc_ip ? 1 : 0)) % 65536);
      ndp = ptr[d];
      if (!n_we_pl) ndp = (ndp & 16'hFF00) | {8'h00, di};
      if (!n_we_ph) ndp = (ndp & 16'h00FF) | {di, 8'h00};
      ptr[i] <= nip;
      ptr[d] <= ndp;
    end
  end

  // Compare process: outputs are combinational, so check mid-cycle.
  always @(negedge clk) begin
    logic [15:0] e_ip, e_dp, e_addr;
    logic [7:0]  e_b;
    logic        e_en;
    if (model_valid) begin
      e_ip   = ptr[p_selector ? 1 : 0];
      e_dp   = ptr[p_selector ? 0 : 1];
      e_addr = addr_dp ? e_dp : e_ip;
      if (!n_oe_pl_alu)      begin e_b = e_dp[7:0];  e_en = 1; end
      else if (!n_oe_ph_alu) begin e_b = e_dp[15:8]; e_en = 1; end
      else                   begin e_b = 8'h00;      e_en = 0; end
      if (!n_oe_pl_alu && !n_oe_ph_alu) protocol_events++;
      check("model_ip", 32'(ip), 32'(e_ip));
      check("model_dp", 32'(dp), 32'(e_dp));
      check("model_address", 32'(address), 32'(e_addr));
      check("model_alu_b", 32'(alu_b), 32'(e_b));
      check("model_alu_b_en", 32'(alu_b_en), 32'(e_en));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input logic sel);
    rst = 0; inc_ip = 0; p_selector = sel; n_we_pl = 1; n_we_ph = 1;
    di = 8'h00; addr_dp = 0; n_oe_pl_alu = 1; n_oe_ph_alu = 1; n_mem_rdy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1'b0);
    rst = 1;

    // 1: reset
    tick();
    idle(1'b0);
    #1;
    check("reset_ip", 32'(ip), 32'h0000);
    check("reset_dp", 32'(dp), 32'h0000);
    check("reset_address", 32'(address), 32'h0000);
    check("reset_alu_b_en", 32'(alu_b_en), 32'h0);

    // 2: DP byte loads
    n_we_pl = 0; di = 8'h34; tick();
    idle(1'b0); n_we_ph = 0; di = 8'h12; tick();
    idle(1'b0); addr_dp = 1; #1;
    check("dp_load_dp", 32'(dp), 32'h1234);
    check("dp_load_address", 32'(address), 32'h1234);
    check("dp_load_ip", 32'(ip), 32'h0000);

    // 3: IP wrap (P0 set to FFFF through the DP role with both strobes low)
    idle(1'b1); n_we_pl = 0; n_we_ph = 0; di = 8'hFF; tick();
    idle(1'b0); inc_ip = 1; tick();
    idle(1'b0); #1;
    check("wrap_ip", 32'(ip), 32'h0000);
    check("wrap_p1", 32'(dp), 32'h1234);

    // 4: jump with return link
    idle(1'b1); n_we_pl = 0; di = 8'h00; tick();
    idle(1'b1); n_we_ph = 0; di = 8'h01; tick();
    idle(1'b0); n_we_pl = 0; di = 8'h00; tick();
    idle(1'b0); n_we_ph = 0; di = 8'h20; tick();
    idle(1'b0); inc_ip = 1; tick();
    idle(1'b1); #1;
    check("swap_ip", 32'(ip), 32'h2000);
    check("swap_dp", 32'(dp), 32'h0101);

    // 5: stall drops strobes, then both apply on one edge
    idle(1'b1); inc_ip = 1; n_we_pl = 0; di = 8'hAA; n_mem_rdy = 1; tick();
    #1;
    check("stall_ip", 32'(ip), 32'h2000);
    check("stall_dp", 32'(dp), 32'h0101);
    n_mem_rdy = 0; tick();
    idle(1'b1); #1;
    check("go_ip", 32'(ip), 32'h2001);
    check("go_dp", 32'(dp), 32'h01AA);

    // 6: ALU B byte selection, then reset mid-sequence
    n_we_pl = 0; di = 8'hEF; tick();
    idle(1'b1); n_we_ph = 0; di = 8'hBE; tick();
    idle(1'b1); n_oe_ph_alu = 0; #1;
    check("alu_ph_b", 32'(alu_b), 32'hBE);
    check("alu_ph_en", 32'(alu_b_en), 32'h1);
    n_oe_pl_alu = 0; #1;
    check("alu_both_b", 32'(alu_b), 32'hEF);
    check("alu_both_en", 32'(alu_b_en), 32'h1);
    inc_ip = 1; rst = 1; tick();
    idle(1'b0); #1;
    check("rst_mid_ip", 32'(ip), 32'(C_RP0));
    check("rst_mid_dp", 32'(dp), 32'(C_RP1));

    // Randomized phase, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      inc_ip      = $urandom_range(0, 1);
      p_selector  = $urandom_range(0, 1);
      n_we_pl     = ($urandom_range(0, 2) != 0);
      n_we_ph     = ($urandom_range(0, 2) != 0);
      di          = 8'($urandom);
      addr_dp     = $urandom_range(0, 1);
      n_oe_pl_alu = ($urandom_range(0, 3) != 0);
      n_oe_ph_alu = ($urandom_range(0, 2) != 0);
      n_mem_rdy   = ($urandom_range(0, 3) == 0);
      tick();
    end

    idle(1'b0);
    tick();
    $display("[TB] protocol errors (both ALU output enables low): %0d", protocol_events);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
